// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// mem_bus_responder: word RAM plus MMIO (cycle counter, tohost, console TX).
// Define MEM_CONSOLE_FIFO_EN for a 4-entry console FIFO; else one holding reg.
// Revision: 1.0
// ============================================================================
module mem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_enable,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halted,
  output logic [31:0] tohost,
  output logic        bus_err,
  output logic        tx_overflow
);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [27:0] MMIO_BASE = 28'hFFFF_FF0;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [63:0]   cnt_q, cnt_d;
  logic [31:0]   snap_q, tohost_q;
  logic          halted_q, bus_err_q, ovf_q;

  logic [AW-1:0] word_idx;
  logic          ram_sel, mmio_sel, unmapped;
  logic          push, pop, push_ok, tx_full;
  logic          unused_addr;

  assign word_idx    = address[AW+1:2];
  assign ram_sel     = (address[31:AW+2] == '0);
  assign mmio_sel    = (address[31:4] == MMIO_BASE);
  assign unmapped    = !ram_sel && !mmio_sel;
  assign unused_addr = ^address[1:0];

  assign push    = we && mmio_sel && (address[3:2] == 2'd3) && byte_enable[0];
  assign pop     = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!tx_full || pop);
  assign cnt_d   = cnt_q + 64'd1;

  // Gated by resetn so a store coinciding with reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (resetn && we && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_enable[i]) mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      halted_q  <= 1'b0;
      tohost_q  <= '0;
      bus_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (mmio_sel && (address[3:2] == 2'd0) && !we) snap_q <= cnt_q[63:32];
      if (we && mmio_sel && (address[3:2] == 2'd2) && !halted_q) begin
        halted_q <= 1'b1;
        tohost_q <= wdata;
      end
      if (we && unmapped) bus_err_q <= 1'b1;
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

`ifdef MEM_CONSOLE_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;

  assign tx_full  = count_q[2];
  assign tx_valid = (count_q != 3'd0);
  assign tx_data  = fifo_q[rd_ptr_q];
  assign count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= wdata[7:0];
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign tx_full  = hold_vld_q;
  assign tx_valid = hold_vld_q;
  assign tx_data  = hold_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_vld_q <= 1'b0;
    end else if (push_ok) begin
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) hold_q <= wdata[7:0];
  end
`endif

  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = mem_q[word_idx];
    end else if (mmio_sel) begin
      case (address[3:2])
        2'd0:    rdata = cnt_q[31:0];
        2'd1:    rdata = snap_q;
        2'd2:    rdata = tohost_q;
        default: rdata = {31'b0, tx_full};
      endcase
    end
  end

  assign halted      = halted_q;
  assign tohost      = tohost_q;
  assign bus_err     = bus_err_q;
  assign tx_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// tb_mem_bus_responder: directed stimulus with an expectation queue checked
// by an independent negedge monitor; console bytes checked on handshake.
module tb_mem_bus_responder;
`ifdef MEM_CONSOLE_FIFO_EN
  localparam int TX_DEPTH = 4;
`else
  localparam int TX_DEPTH = 1;
`endif
  localparam int K_RDATA = 0, K_HALT = 1, K_TOHOST = 2, K_BUSERR = 3,
                 K_OVF = 4, K_TXV = 5, K_TXD = 6;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] txq[$];
  int         vectors = 0;
  int         miscompares = 0;

  logic        clk = 1'b0, resetn = 1'b0, we = 1'b0, tx_ready = 1'b0, chk = 1'b0;
  logic [31:0] address = '0, wdata = '0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] rdata, tohost;
  logic [7:0]  tx_data;
  logic        tx_valid, halted, bus_err, tx_overflow;

  always #5 clk = ~clk;

  mem_bus_responder #(.DEPTH_WORDS(4096), .INIT_FILE("")) dut (
    .clk(clk), .resetn(resetn), .address(address), .wdata(wdata),
    .byte_enable(byte_enable), .we(we), .rdata(rdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .halted(halted), .tohost(tohost),
    .bus_err(bus_err), .tx_overflow(tx_overflow)
  );

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RDATA:  return rdata;
      K_HALT:   return {31'b0, halted};
      K_TOHOST: return tohost;
      K_BUSERR: return {31'b0, bus_err};
      K_OVF:    return {31'b0, tx_overflow};
      K_TXV:    return {31'b0, tx_valid};
      default:  return {24'b0, tx_data};
    endcase
  endfunction

  exp_t        m_e;
  logic [31:0] m_a;
  logic [7:0]  m_b;

  always @(negedge clk) begin
    if (chk) begin
      while (expq.size() > 0) begin
        m_e = expq.pop_front();
        m_a = actual(m_e.kind);
        vectors++;
        if (m_a !== m_e.val) begin
          miscompares++;
          $display("FAIL %s: got %h, expected %h", m_e.name, m_a, m_e.val);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      vectors++;
      if (txq.size() == 0) begin
        miscompares++;
        $display("FAIL tx_unexpected: got %h, expected no byte", tx_data);
      end else begin
        m_b = txq.pop_front();
        if (tx_data !== m_b) begin
          miscompares++;
          $display("FAIL tx_byte: got %h, expected %h", tx_data, m_b);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    chk = 1'b0;
    we = 1'b0;
    byte_enable = 4'b0;
  endtask

  task automatic drv(input logic [31:0] a, input logic w, input logic [3:0] be,
                     input logic [31:0] d);
    address = a; we = w; byte_enable = be; wdata = d;
  endtask

  task automatic expv(input int k, input logic [31:0] v, input string n);
    expq.push_back('{k, v, n});
    chk = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
    drv(a, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, v, n);
    cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    drv(a, 1'b1, be, d);
    cyc();
  endtask

  task automatic drain(input string n);
    int k;
    for (k = 0; k < 32 && (txq.size() != 0 || tx_valid); k++) cyc();
    vectors++;
    if (txq.size() != 0 || tx_valid) begin
      miscompares++;
      $display("FAIL %s: got %0d bytes outstanding, expected 0", n, txq.size());
    end
  endtask

  task automatic push_byte(input logic [7:0] c, input logic expect_out);
    drv(32'hFFFF_FF0C, 1'b1, 4'b0001, {24'b0, c});
    if (expect_out) txq.push_back(c);
    cyc();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    drv(32'hFFFF_FF00, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, 32'h0, "cnt_reset");
    expv(K_HALT, 32'h0, "halted_reset");
    expv(K_TOHOST, 32'h0, "tohost_reset");
    expv(K_BUSERR, 32'h0, "buserr_reset");
    expv(K_OVF, 32'h0, "ovf_reset");
    expv(K_TXV, 32'h0, "txvalid_reset");
    cyc();
    rd(32'hFFFF_FF00, 32'h1, "cnt_inc");

    wr(32'h10, 4'hF, 32'hAABB_CCDD);
    wr(32'h10, 4'b0010, 32'h0000_EE00);
    rd(32'h10, 32'hAABB_EEDD, "ram_lane");
    wr(32'h10, 4'b0000, 32'hFFFF_FFFF);
    rd(32'h13, 32'hAABB_EEDD, "ram_be0_unaligned");
    wr(32'h14, 4'hF, 32'h1234_5678);
    rd(32'h14, 32'h1234_5678, "ram_word5");
    wr(32'h0, 4'hF, 32'hCAFE_F00D);
    wr(32'h3FFC, 4'hF, 32'h0BAD_CAFE);
    rd(32'h3FFC, 32'h0BAD_CAFE, "ram_last_word");
    rd(32'h4000, 32'h0, "ram_end_unmapped");

    rd(32'h8000_0000, 32'h0, "unmapped_rd");
    drv(32'hFFFF_FF00, 1'b0, 4'b0, 32'b0);
    expv(K_BUSERR, 32'h0, "buserr_after_rd");
    cyc();
    wr(32'h4000_0000, 4'hF, 32'h1111_1111);
    drv(32'h10, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, 32'hAABB_EEDD, "ram_after_unmapped_wr");
    expv(K_BUSERR, 32'h1, "buserr_set");
    cyc();

    wr(32'hFFFF_FF08, 4'hF, 32'h1);
    wr(32'hFFFF_FF08, 4'hF, 32'h2);
    drv(32'hFFFF_FF08, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, 32'h1, "tohost_rd");
    expv(K_HALT, 32'h1, "halted_set");
    expv(K_TOHOST, 32'h1, "tohost_first");
    cyc();

    dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
    rd(32'hFFFF_FF00, 32'hFFFF_FFFF, "cnt_lo_pre_carry");
    rd(32'hFFFF_FF04, 32'h1, "snap_hi_carry");
    rd(32'hFFFF_FF00, 32'h1, "cnt_lo_post_carry");
    wr(32'hFFFF_FF04, 4'hF, 32'h99);
    rd(32'hFFFF_FF04, 32'h2, "snap_hi_after_wr");

    drv(32'hFFFF_FF0C, 1'b1, 4'b0010, 32'h41);
    cyc();
    drv(32'hFFFF_FF0C, 1'b0, 4'b0, 32'b0);
    expv(K_TXV, 32'h0, "no_push_be0_clear");
    cyc();
    for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i), i < TX_DEPTH);
    drv(32'hFFFF_FF0C, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, 32'h1, "tx_full");
    expv(K_TXV, 32'h1, "tx_valid_held");
    expv(K_TXD, 32'h41, "tx_head_A");
    expv(K_OVF, 32'h1, "tx_overflow");
    cyc();
    tx_ready = 1'b1;
    drain("drain_AtoD");
    rd(32'hFFFF_FF0C, 32'h0, "tx_empty");
    tx_ready = 1'b0;

    push_byte(8'h58, 1'b0);
    txq.delete();
    drv(32'h14, 1'b1, 4'hF, 32'hDEAD_BEEF);
    resetn = 1'b0;
    expv(K_HALT, 32'h0, "rst_halted");
    expv(K_TOHOST, 32'h0, "rst_tohost");
    expv(K_BUSERR, 32'h0, "rst_buserr");
    expv(K_OVF, 32'h0, "rst_ovf");
    expv(K_TXV, 32'h0, "rst_txvalid");
    cyc();
    cyc();
    resetn = 1'b1;
    rd(32'hFFFF_FF00, 32'h0, "cnt_after_rst");
    rd(32'h14, 32'h1234_5678, "ram_kept_rst");
    rd(32'h10, 32'hAABB_EEDD, "ram_kept_rst2");

    for (int i = 0; i < TX_DEPTH; i++) push_byte(8'h50 + 8'(i), 1'b1);
    rd(32'hFFFF_FF0C, 32'h1, "tx_full2");
    drv(32'hFFFF_FF0C, 1'b1, 4'b0001, 32'h5A);
    tx_ready = 1'b1;
    txq.push_back(8'h5A);
    cyc();
    drain("drain_Z_last");
    drv(32'hFFFF_FF0C, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, 32'h0, "tx_empty2");
    expv(K_OVF, 32'h0, "no_ovf_simul");
    cyc();
    tx_ready = 1'b0;

    wr(32'hFFFF_FF08, 4'hF, 32'h55);
    drv(32'hFFFF_FF08, 1'b0, 4'b0, 32'b0);
    expv(K_RDATA, 32'h55, "tohost_rearm");
    expv(K_HALT, 32'h1, "halted_rearm");
    cyc();

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
